// File: rtl/sysid_check_ctrl.sv
// -----------------------------------------------------------------------------
// sysid_check_ctrl
//
// Avalon-MM read sequencer for the system-ID slave. After reset (if AUTO_START)
// or on a start request it reads word 0 (system ID) and word 1 (build
// timestamp), then compares them against the build constants. The pass/fail
// result gates the hardware/software match check at boot.
//
// Ports:
//   clock            single rising-edge clock
//   reset_n          synchronous active-low reset
//   start            request a check (honoured only in IDLE or DONE)
//   avm_address      slave word address (0 = ID, 1 = timestamp)
//   avm_read         read strobe, held until the slave drops waitrequest
//   avm_waitrequest  slave stall
//   avm_readdata     slave read data, valid READ_LATENCY cycles after accept
//   busy             a check is in progress
//   done             level, high while the result is being presented
//   pass             check result, valid while done=1
//   err_code         0 ok, 1 ID mismatch, 2 TS mismatch, 3 timeout
//   id_word          captured word 0
//   ts_word          captured word 1
// -----------------------------------------------------------------------------
module sysid_check_ctrl #(
    parameter logic [31:0] EXPECTED_ID  = 32'd0,
    parameter logic [31:0] EXPECTED_TS  = 32'd0,
    parameter bit          CHECK_TS     = 1'b1,
    parameter int unsigned READ_LATENCY = 0,
    parameter int unsigned TIMEOUT      = 255,
    parameter bit          AUTO_START   = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [1:0]  err_code,
    output logic [31:0] id_word,
    output logic [31:0] ts_word
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ID,
        S_WT_ID,
        S_RD_TS,
        S_WT_TS,
        S_CMP,
        S_DONE
    } state_t;

    localparam logic [1:0]  LAT        = READ_LATENCY[1:0];
    localparam int unsigned TMO_LAST_I = TIMEOUT - 1;
    // Last counter value at which a capture is still allowed.
    localparam logic [15:0] TMO_LAST   = TMO_LAST_I[15:0];

    state_t      state, state_nx;
    logic        auto_pend, auto_nx;
    logic [15:0] tmo_cnt, tmo_nx;
    logic [1:0]  lat_cnt, lat_nx;
    logic        busy_nx, done_nx, pass_nx, read_nx, addr_nx;
    logic [1:0]  err_nx;
    logic [31:0] id_nx, ts_nx;

    logic        in_rd, in_wt, on_id, accept, capture;

    always_comb begin
        in_rd  = (state == S_RD_ID) || (state == S_RD_TS);
        in_wt  = (state == S_WT_ID) || (state == S_WT_TS);
        on_id  = (state == S_RD_ID) || (state == S_WT_ID);
        accept = in_rd && avm_read && !avm_waitrequest;
        // With zero latency the data is on the bus in the accept cycle;
        // otherwise it arrives on the last counted wait cycle.
        if (READ_LATENCY == 0)
            capture = accept;
        else
            capture = in_wt && (lat_cnt == LAT);

        state_nx = state;
        auto_nx  = auto_pend;
        tmo_nx   = tmo_cnt;
        lat_nx   = lat_cnt;
        pass_nx  = pass;
        err_nx   = err_code;
        id_nx    = id_word;
        ts_nx    = ts_word;

        case (state)
            S_IDLE: begin
                if (auto_pend || start) begin
                    state_nx = S_RD_ID;
                    auto_nx  = 1'b0;
                    tmo_nx   = '0;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_nx = S_RD_ID;
                    pass_nx  = 1'b0;
                    err_nx   = 2'd0;
                    tmo_nx   = '0;
                end
            end
            S_RD_ID, S_WT_ID, S_RD_TS, S_WT_TS: begin
                if (capture) begin
                    if (on_id) begin
                        id_nx    = avm_readdata;
                        state_nx = S_RD_TS;
                        tmo_nx   = '0;
                    end else begin
                        ts_nx    = avm_readdata;
                        state_nx = S_CMP;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    // Slave never answered in time; the word keeps its old value.
                    state_nx = S_DONE;
                    err_nx   = 2'd3;
                    pass_nx  = 1'b0;
                end else begin
                    tmo_nx = tmo_cnt + 16'd1;
                    if (accept) begin
                        state_nx = on_id ? S_WT_ID : S_WT_TS;
                        lat_nx   = 2'd1;
                    end else if (in_wt) begin
                        lat_nx = lat_cnt + 2'd1;
                    end
                end
            end
            S_CMP: begin
                state_nx = S_DONE;
                if (id_word != EXPECTED_ID) begin
                    err_nx  = 2'd1;
                    pass_nx = 1'b0;
                end else if (CHECK_TS && (ts_word != EXPECTED_TS)) begin
                    err_nx  = 2'd2;
                    pass_nx = 1'b0;
                end else begin
                    err_nx  = 2'd0;
                    pass_nx = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        // Status and bus outputs are registered from the next state so they
        // change on the same edge as the state itself.
        busy_nx = !((state_nx == S_IDLE) || (state_nx == S_DONE));
        done_nx = (state_nx == S_DONE);
        read_nx = (state_nx == S_RD_ID) || (state_nx == S_RD_TS);
        addr_nx = (state_nx == S_RD_TS) || (state_nx == S_WT_TS);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            auto_pend   <= AUTO_START;
            tmo_cnt     <= '0;
            lat_cnt     <= '0;
            avm_read    <= 1'b0;
            avm_address <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_code    <= 2'd0;
            id_word     <= '0;
            ts_word     <= '0;
        end else begin
            state       <= state_nx;
            auto_pend   <= auto_nx;
            tmo_cnt     <= tmo_nx;
            lat_cnt     <= lat_nx;
            avm_read    <= read_nx;
            avm_address <= addr_nx;
            busy        <= busy_nx;
            done        <= done_nx;
            pass        <= pass_nx;
            err_code    <= err_nx;
            id_word     <= id_nx;
            ts_word     <= ts_nx;
        end
    end

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sysid_check_ctrl
//
// Four sequencer instances share one system-ID word pair:
//   dut0  baseline, L=0, TIMEOUT=16, stuck-waitrequest control
//   dut1  L=2, slave can stall 3 cycles on every read
//   dut2  EXPECTED_TS wrong, CHECK_TS=1
//   dut3  EXPECTED_TS wrong, CHECK_TS=0
// Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_sysid_check_ctrl;

    localparam logic [31:0] TS_GOOD  = 32'h606A_6C20;
    localparam logic [31:0] TS_OTHER = 32'h1234_5678;
    localparam logic [31:0] BAD      = 32'hBAD0_BAD0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  rst_n;
    logic [3:0]  start;
    logic        rd    [4];
    logic        ad    [4];
    logic        wr    [4];
    logic [31:0] rdata [4];
    logic        busy  [4];
    logic        done  [4];
    logic        pass  [4];
    logic [1:0]  err   [4];
    logic [31:0] idw   [4];
    logic [31:0] tsw   [4];

    logic [31:0] w0, w1;
    logic        stuck0, stall_en;
    logic [1:0]  p_vld = 2'b00;
    logic [1:0]  p_ad  = 2'b00;
    logic [1:0]  scnt  = 2'd0;

    int vectors     = 0;
    int miscompares = 0;

    // Slave models: L=0 slaves drive data only in the accept cycle, the L=2
    // slave only in the cycle two edges after accept; garbage otherwise.
    always_comb begin
        wr[0] = stuck0;
        wr[1] = stall_en && rd[1] && (scnt < 2'd3);
        wr[2] = 1'b0;
        wr[3] = 1'b0;
        rdata[0] = (rd[0] && !wr[0]) ? (ad[0] ? w1 : w0) : BAD;
        rdata[1] = p_vld[1] ? (p_ad[1] ? w1 : w0) : BAD;
        rdata[2] = (rd[2] && !wr[2]) ? (ad[2] ? w1 : w0) : BAD;
        rdata[3] = (rd[3] && !wr[3]) ? (ad[3] ? w1 : w0) : BAD;
    end

    always @(posedge clk) begin
        p_vld <= {p_vld[0], rd[1] && !wr[1]};
        p_ad  <= {p_ad[0], ad[1]};
        if (!rd[1])
            scnt <= 2'd0;
        else if (wr[1])
            scnt <= scnt + 2'd1;
    end

    sysid_check_ctrl #(.EXPECTED_ID(32'd0), .EXPECTED_TS(TS_GOOD), .CHECK_TS(1'b1),
                       .READ_LATENCY(0), .TIMEOUT(16), .AUTO_START(1'b1)) dut0 (
        .clock(clk), .reset_n(rst_n[0]), .start(start[0]),
        .avm_address(ad[0]), .avm_read(rd[0]), .avm_waitrequest(wr[0]),
        .avm_readdata(rdata[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_code(err[0]), .id_word(idw[0]), .ts_word(tsw[0]));

    sysid_check_ctrl #(.EXPECTED_ID(32'd0), .EXPECTED_TS(TS_GOOD), .CHECK_TS(1'b1),
                       .READ_LATENCY(2), .TIMEOUT(255), .AUTO_START(1'b1)) dut1 (
        .clock(clk), .reset_n(rst_n[1]), .start(start[1]),
        .avm_address(ad[1]), .avm_read(rd[1]), .avm_waitrequest(wr[1]),
        .avm_readdata(rdata[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_code(err[1]), .id_word(idw[1]), .ts_word(tsw[1]));

    sysid_check_ctrl #(.EXPECTED_ID(32'd0), .EXPECTED_TS(TS_OTHER), .CHECK_TS(1'b1),
                       .READ_LATENCY(0), .TIMEOUT(255), .AUTO_START(1'b1)) dut2 (
        .clock(clk), .reset_n(rst_n[2]), .start(start[2]),
        .avm_address(ad[2]), .avm_read(rd[2]), .avm_waitrequest(wr[2]),
        .avm_readdata(rdata[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
        .err_code(err[2]), .id_word(idw[2]), .ts_word(tsw[2]));

    sysid_check_ctrl #(.EXPECTED_ID(32'd0), .EXPECTED_TS(TS_OTHER), .CHECK_TS(1'b0),
                       .READ_LATENCY(0), .TIMEOUT(255), .AUTO_START(1'b1)) dut3 (
        .clock(clk), .reset_n(rst_n[3]), .start(start[3]),
        .avm_address(ad[3]), .avm_read(rd[3]), .avm_waitrequest(wr[3]),
        .avm_readdata(rdata[3]), .busy(busy[3]), .done(done[3]), .pass(pass[3]),
        .err_code(err[3]), .id_word(idw[3]), .ts_word(tsw[3]));

    task automatic tick;
        @(negedge clk);
    endtask

    // Observed vector layout: {read, read&addr, busy, done, pass, err[1:0]}.
    task automatic test_reset;
        logic [6:0] obs;
        rst_n = 4'h0; start = 4'h0;
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            obs = {rd[i], rd[i] & ad[i], busy[i], done[i], pass[i], err[i]};
            vectors++;
            if (obs !== 7'b0 || idw[i] !== 32'd0 || tsw[i] !== 32'd0) begin
                miscompares++;
                $display("FAIL reset dut%0d got=%b id=%h ts=%h exp=0000000 id=0 ts=0",
                         i, obs, idw[i], tsw[i]);
            end
        end
    endtask

    task automatic test_auto_run;
        logic [6:0] obs, exp_v;
        logic       ex_rd, ex_ad;
        logic [4:0] ex_st;
        rst_n = 4'hF;
        for (int k = 1; k <= 8; k++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                if (i == 1) begin
                    ex_rd = (k == 1) || (k == 4);
                    ex_ad = (k == 4);
                    ex_st = (k == 8) ? 5'b01100 : 5'b10000;
                end else begin
                    ex_rd = (k <= 2);
                    ex_ad = (k == 2);
                    ex_st = (k < 4) ? 5'b10000 : ((i == 2) ? 5'b01010 : 5'b01100);
                end
                obs   = {rd[i], rd[i] & ad[i], busy[i], done[i], pass[i], err[i]};
                exp_v = {ex_rd, ex_ad, ex_st};
                vectors++;
                if (obs !== exp_v) begin
                    miscompares++;
                    $display("FAIL auto_run k=%0d dut%0d got=%b exp=%b", k, i, obs, exp_v);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (idw[i] !== 32'd0 || tsw[i] !== TS_GOOD) begin
                miscompares++;
                $display("FAIL auto_words dut%0d got id=%h ts=%h exp id=0 ts=%h",
                         i, idw[i], tsw[i], TS_GOOD);
            end
        end
    endtask

    task automatic test_id_priority;
        logic [4:0] obs, exp_v;
        w0 = 32'hDEAD_BEEF;
        start[2] = 1'b1; start[3] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            start[2] = 1'b0; start[3] = 1'b0;
            for (int i = 2; i < 4; i++) begin
                obs   = {busy[i], done[i], pass[i], err[i]};
                exp_v = (k < 4) ? 5'b10000 : 5'b01001;
                vectors++;
                if (obs !== exp_v) begin
                    miscompares++;
                    $display("FAIL id_priority k=%0d dut%0d got=%b exp=%b", k, i, obs, exp_v);
                end
            end
        end
        for (int i = 2; i < 4; i++) begin
            vectors++;
            if (idw[i] !== 32'hDEAD_BEEF || tsw[i] !== TS_GOOD) begin
                miscompares++;
                $display("FAIL id_words dut%0d got id=%h ts=%h exp id=deadbeef ts=%h",
                         i, idw[i], tsw[i], TS_GOOD);
            end
        end
        w0 = 32'd0;
    endtask

    task automatic test_waitstates;
        logic [6:0] obs, exp_v;
        logic       ex_rd;
        stall_en = 1'b1;
        start[1] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            start[1] = 1'b0;
            ex_rd = (k <= 4) || ((k >= 7) && (k <= 10));
            exp_v = {ex_rd, ex_rd && (k >= 7), (k == 14) ? 5'b01100 : 5'b10000};
            obs   = {rd[1], rd[1] & ad[1], busy[1], done[1], pass[1], err[1]};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL waitstates k=%0d got=%b exp=%b", k, obs, exp_v);
            end
        end
        vectors++;
        if (idw[1] !== 32'd0 || tsw[1] !== TS_GOOD) begin
            miscompares++;
            $display("FAIL wait_words got id=%h ts=%h exp id=0 ts=%h", idw[1], tsw[1], TS_GOOD);
        end
        stall_en = 1'b0;
    endtask

    task automatic test_timeout;
        logic [6:0] obs, exp_v;
        stuck0 = 1'b1;
        start[0] = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            start[0] = 1'b0;
            exp_v = {(k <= 16), 1'b0, (k == 17) ? 5'b01011 : 5'b10000};
            obs   = {rd[0], rd[0] & ad[0], busy[0], done[0], pass[0], err[0]};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL timeout k=%0d got=%b exp=%b", k, obs, exp_v);
            end
        end
        vectors++;
        if (idw[0] !== 32'd0 || tsw[0] !== TS_GOOD) begin
            miscompares++;
            $display("FAIL timeout_words got id=%h ts=%h exp id=0 ts=%h", idw[0], tsw[0], TS_GOOD);
        end
        stuck0 = 1'b0;
        start[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            start[0] = 1'b0;
            exp_v = {(k <= 2), (k == 2), (k == 4) ? 5'b01100 : 5'b10000};
            obs   = {rd[0], rd[0] & ad[0], busy[0], done[0], pass[0], err[0]};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL timeout_recover k=%0d got=%b exp=%b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_midrun;
        logic [6:0] obs, exp_v;
        start[1] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            start[1] = (k == 2);   // pulse while busy, must be ignored
            exp_v = {(k == 1) || (k == 4), (k == 4), 5'b10000};
            obs   = {rd[1], rd[1] & ad[1], busy[1], done[1], pass[1], err[1]};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL midrun k=%0d got=%b exp=%b", k, obs, exp_v);
            end
        end
        rst_n[1] = 1'b0;
        tick();
        obs = {rd[1], rd[1] & ad[1], busy[1], done[1], pass[1], err[1]};
        vectors++;
        if (obs !== 7'b0 || idw[1] !== 32'd0 || tsw[1] !== 32'd0) begin
            miscompares++;
            $display("FAIL midrun_reset got=%b id=%h ts=%h exp=0000000 id=0 ts=0",
                     obs, idw[1], tsw[1]);
        end
        rst_n[1] = 1'b1;
        for (int k = 7; k <= 14; k++) begin
            tick();
            exp_v = {(k == 7) || (k == 10), (k == 10), (k == 14) ? 5'b01100 : 5'b10000};
            obs   = {rd[1], rd[1] & ad[1], busy[1], done[1], pass[1], err[1]};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL midrun_rerun k=%0d got=%b exp=%b", k, obs, exp_v);
            end
        end
        vectors++;
        if (idw[1] !== 32'd0 || tsw[1] !== TS_GOOD) begin
            miscompares++;
            $display("FAIL midrun_words got id=%h ts=%h exp id=0 ts=%h", idw[1], tsw[1], TS_GOOD);
        end
    endtask

    task automatic test_back_to_back;
        logic [6:0] obs, exp_v;
        logic       ex_done;
        start[3] = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            ex_done = (k == 4) || (k == 8) || (k == 9);
            exp_v = {(k == 1) || (k == 2) || (k == 5) || (k == 6),
                     (k == 2) || (k == 6),
                     ex_done ? 5'b01100 : 5'b10000};
            obs   = {rd[3], rd[3] & ad[3], busy[3], done[3], pass[3], err[3]};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL back_to_back k=%0d got=%b exp=%b", k, obs, exp_v);
            end
            if (k == 8) start[3] = 1'b0;
        end
    endtask

    initial begin
        w0 = 32'd0; w1 = TS_GOOD;
        stuck0 = 1'b0; stall_en = 1'b0;
        test_reset();
        test_auto_run();
        test_id_priority();
        test_waitstates();
        test_timeout();
        test_reset_midrun();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sysid_check_ctrl.md
# sysid_check_ctrl

Avalon-MM master sequencer that reads the system-ID slave after reset or on request, captures its two words (word 0 = system ID, word 1 = build timestamp), and compares them against the expected build constants. It sits between the system-ID slave's control port and the boot/status logic. Its pass/fail result gates the "hardware matches software" check before the processor or test harness proceeds. It tolerates slave wait-states and a fixed read latency, and it times out if the slave does not respond.

## Interface
- EXPECTED_ID, 32'd0, expected value of word 0
- EXPECTED_TS, 32'd0, expected value of word 1
- CHECK_TS, 1, 1 = a word 1 mismatch fails the check; 0 = word 1 is captured only
- READ_LATENCY, 0, fixed cycles from read accept to valid readdata (0..3)
- TIMEOUT, 255, maximum cycles from read assertion to data capture (1..65535)
- AUTO_START, 1, 1 = run one check automatically after reset release

- clock  in  1  single clock, all logic rising-edge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  request a check; sampled only in IDLE or DONE
- avm_address  out  1  slave word address
- avm_read  out  1  read strobe
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  slave read data
- busy  out  1  high in any state other than IDLE or DONE
- done  out  1  level, high in DONE
- pass  out  1  valid while done=1
- err_code  out  2  0 = ok, 1 = ID mismatch, 2 = TS mismatch, 3 = timeout; valid while done=1
- id_word  out  32  captured word 0
- ts_word  out  32  captured word 1

## Operation
- States: IDLE, RD_ID, WT_ID, RD_TS, WT_TS, CMP, DONE.
- Reset values: state IDLE, avm_read 0, avm_address 0, busy 0, done 0, pass 0, err_code 0, id_word 0, ts_word 0, timeout counter 0, pending-autostart flag = AUTO_START.
- IDLE: a set pending-autostart flag or start=1 moves to RD_ID. The pending-autostart flag clears when leaving IDLE.
- DONE: start=1 moves to RD_ID and clears done, pass and err_code. start is ignored in all other states.
- RD_ID:
  - avm_address=0, avm_read=1, held stable while avm_waitrequest=1.
  - Accept occurs on the cycle with avm_read=1 and avm_waitrequest=0.
  - READ_LATENCY=0: capture avm_readdata into id_word on the accept edge and go to RD_TS.
  - READ_LATENCY>0: go to WT_ID.
- WT_ID: avm_read=0. Count READ_LATENCY cycles from accept, capture id_word on the last one, then go to RD_TS.
- RD_TS / WT_TS: identical to RD_ID / WT_ID with avm_address=1, capturing ts_word.
- CMP: a single cycle that evaluates in priority order:
  - id_word != EXPECTED_ID -> err_code=1
  - else if CHECK_TS and ts_word != EXPECTED_TS -> err_code=2
  - else err_code=0
  - pass = (err_code==0). Then go to DONE.
- Timeout:
  - The counter clears on entry to RD_ID or RD_TS and increments each cycle in RD_x/WT_x.
  - When it reaches TIMEOUT before capture: deassert avm_read, set err_code=3 and pass=0, go directly to DONE. The word being read keeps its previous value.
- Comparison is exact 32-bit equality. There is no masking.

## Timing
- avm_read/avm_address are registered outputs, asserted the cycle after the state entry edge.
- Zero wait-states and READ_LATENCY=0: done rises on the 4th rising edge after the edge that samples start (RD_ID, RD_TS, CMP, DONE).
- Each waitrequest cycle adds 1 cycle per read. READ_LATENCY=L adds L cycles per read.
- avm_read drops on the edge following accept. There is never a back-to-back read to the same address.
- busy rises on the edge leaving IDLE/DONE and falls on the edge entering DONE.
- reset_n low on any edge, mid-read included, forces all reset values on that edge; avm_read is 0 the next cycle. If AUTO_START=1, a fresh check begins after release, in the first IDLE cycle.
- start held high continuously in DONE reruns the check back-to-back. done is low for the entire run.

## Test plan
- Slave returns word0=0, word1=0x606A6C20; EXPECTED_ID=0, EXPECTED_TS=0x606A6C20, no waits, L=0 -> auto-run after reset; done at edge 4; pass=1, err_code=0, ts_word=0x606A6C20.
- Same slave, EXPECTED_TS=0x12345678: CHECK_TS=1 -> pass=0, err_code=2; CHECK_TS=0 -> pass=1, err_code=0.
- Slave word0=0xDEADBEEF vs EXPECTED_ID=0, with the timestamp also wrong -> err_code=1 (ID has priority), pass=0.
- waitrequest high 3 cycles on each read, L=2 -> avm_address/avm_read stable through the stalls; done 10 cycles later than the baseline; values correct.
- waitrequest stuck high, TIMEOUT=16 -> avm_read drops after 16 cycles; done=1, err_code=3, pass=0. Then release waitrequest and pulse start -> pass=1.
- reset_n low for 1 cycle while in WT_TS -> outputs at reset values next cycle; the auto-run then completes with pass=1. start pulses while busy have no effect.
